cpu_clk_ctrl: RTL

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: turns divider ticks into one-cycle CPU clock-enable pulses
// in free-run or single-step mode, with a debounced step button, halt handling and
// a saturating count of issued pulses.
module cpu_clk_ctrl #(
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_in,
    input  logic             clr_cnt,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES + 1);
    // Counter value on the last cycle of the stability window
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStep,
        StHalt
    } state_e;

    logic             tick_d;
    logic             tick_rise;
    logic             step_meta;
    logic             step_sync;
    logic             step_db;
    logic [DEB_W-1:0] deb_cnt;
    logic             step_press;
    state_e           state_q;
    state_e           state_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             running_q;
    logic             halted_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    assign tick_rise = tick_in & ~tick_d;

    // Tick edge detector and two-flop synchronizer for the raw step button
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_d    <= 1'b0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            tick_d    <= tick_in;
            step_meta <= step_btn;
            step_sync <= step_meta;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples;
    // step_press fires together with a 0->1 change of step_db
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            step_db    <= 1'b0;
            deb_cnt    <= '0;
            step_press <= 1'b0;
        end else if (step_sync != step_db) begin
            if (deb_cnt == DEB_LAST) begin
                step_db    <= step_sync;
                deb_cnt    <= '0;
                step_press <= step_sync;
            end else begin
                deb_cnt    <= deb_cnt + DEB_W'(1);
                step_press <= 1'b0;
            end
        end else begin
            deb_cnt    <= '0;
            step_press <= 1'b0;
        end
    end

    // Next-state and pulse request; halt always has top priority
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (halt_in) begin
                    state_d = StHalt;
                end else if (run_sw) begin
                    state_d = StRun;
                end else if (step_press) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt_in) begin
                    state_d = StHalt;
                end else if (!run_sw) begin
                    state_d = StIdle;
                end else if (tick_rise) begin
                    cpu_en_d = 1'b1;
                end
            end
            StStep: begin
                if (halt_in) begin
                    state_d = StHalt;
                end else if (tick_rise) begin
                    cpu_en_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StHalt: begin
                if (!halt_in && !run_sw) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State register with registered output decodes (aligned with state_q)
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= (state_d == StRun);
            halted_q  <= (state_d == StHalt);
        end
    end

    // Pulse counter: clear beats increment, saturates at all-ones
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (clr_cnt) begin
            cycle_cnt_q <= '0;
        end else if (cpu_en_q && (cycle_cnt_q != CNT_MAX)) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        end
    end

    assign cpu_en    = cpu_en_q;
    assign running   = running_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
